// File: rtl/motion_pkg.sv
// Encodings shared between the limit supervisor and the Motion stage:
// supervisor state values and movementEnable bit positions.
package motion_pkg;

  typedef enum logic [1:0] {
    SUP_IDLE  = 2'b00,
    SUP_RUN   = 2'b01,
    SUP_FAULT = 2'b10
  } supState_t;

  localparam int ME_GLOBAL = 6;
  localparam int ME_XB     = 5;
  localparam int ME_XA     = 4;
  localparam int ME_YA     = 3;
  localparam int ME_YB     = 2;
  localparam int ME_ZA     = 1;
  localparam int ME_ZB     = 0;

endpackage

// File: rtl/press_debounce.sv
// Start-button conditioner: polarity fix, 2-flop sync, hold counter and a
// single-cycle press pulse once the button has been held DEBOUNCE cycles.
module press_debounce
  import motion_pkg::*;
#(
  parameter int DEBOUNCE      = 50000,
  parameter int START_ACT_LOW = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic startButton,
  output logic pressPulse
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             startSync_p0;
  logic             startSync_p1;
  logic [CNT_W-1:0] holdCnt;
  logic             fired;

  // Polarity is folded in ahead of the synchronizer so reset-cleared flops read "not pressed".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      startSync_p0 <= 1'b0;
      startSync_p1 <= 1'b0;
      holdCnt      <= '0;
      fired        <= 1'b0;
      pressPulse   <= 1'b0;
    end else begin
      startSync_p0 <= startButton ^ (START_ACT_LOW != 0);
      startSync_p1 <= startSync_p0;
      pressPulse   <= 1'b0;
      if (!startSync_p1) begin
        holdCnt <= '0;
        fired   <= 1'b0;
      end else if (holdCnt == CNT_LAST) begin
        pressPulse <= !fired;
        fired      <= 1'b1;
      end else begin
        holdCnt <= holdCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/axis_limit_supervisor.sv
// Builds the 7-bit movementEnable vector for Motion: per-axis soft-limit gating
// plus an IDLE/RUN/FAULT supervisor driven by the start button and e-stop.
module axis_limit_supervisor
  import motion_pkg::*;
#(
  parameter int X_UPPER       = 2600,
  parameter int Y_UPPER       = 2300,
  parameter int Z_UPPER       = 2600,
  parameter int LOWER         = 0,
  parameter int OVERTRAVEL    = 64,
  parameter int DEBOUNCE      = 50000,
  parameter int START_ACT_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startButton,
  input  logic        estop,
  input  logic [15:0] xAxisPointer,
  input  logic [15:0] yAxisPointer,
  input  logic [15:0] zAxisPointer,
  output logic [6:0]  movementEnable,
  output logic [1:0]  supState,
  output logic [2:0]  faultAxis
);

  localparam int LOW_WIN = (LOWER > OVERTRAVEL) ? (LOWER - OVERTRAVEL) : 0;

  logic      pressPulse;
  logic      estopSync_p0;
  logic      estopSync_p1;
  logic [2:0] inRange;
  logic [2:0] dirA;
  logic [2:0] dirB;
  logic [6:0] runMask;
  supState_t state;

  press_debounce #(
    .DEBOUNCE      (DEBOUNCE),
    .START_ACT_LOW (START_ACT_LOW)
  ) u_press (
    .clk         (clk),
    .reset       (reset),
    .startButton (startButton),
    .pressPulse  (pressPulse)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estopSync_p0 <= 1'b0;
      estopSync_p1 <= 1'b0;
    end else begin
      estopSync_p0 <= estop;
      estopSync_p1 <= estopSync_p0;
    end
  end

  // Index 0/1/2 = x/y/z; all compares are 17 bits wide so UPPER+OVERTRAVEL never wraps.
  for (genvar i = 0; i < 3; i++) begin : g_axis
    localparam int UP = (i == 0) ? X_UPPER : (i == 1) ? Y_UPPER : Z_UPPER;
    logic [15:0] ptr;
    logic        lowOk;
    assign ptr = (i == 0) ? xAxisPointer : (i == 1) ? yAxisPointer : zAxisPointer;
    if (LOW_WIN > 0) begin : g_low
      assign lowOk = {1'b0, ptr} >= 17'(LOW_WIN);
    end else begin : g_nolow
      assign lowOk = 1'b1;
    end
    assign inRange[i] = lowOk && ({1'b0, ptr} <= 17'(UP + OVERTRAVEL));
    assign dirA[i]    = {1'b0, ptr} < 17'(UP);
    assign dirB[i]    = {1'b0, ptr} > 17'(LOWER);
  end

  always_comb begin
    runMask            = '0;
    runMask[ME_GLOBAL] = 1'b1;
    runMask[ME_XA]     = dirA[0];
    runMask[ME_XB]     = dirB[0];
    runMask[ME_YA]     = dirA[1];
    runMask[ME_YB]     = dirB[1];
    runMask[ME_ZA]     = dirA[2];
    runMask[ME_ZB]     = dirB[2];
  end

  // Enables are loaded from the state being entered, so they switch on the same edge as supState.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= SUP_IDLE;
      faultAxis      <= 3'b000;
      movementEnable <= '0;
    end else begin
      case (state)
        SUP_IDLE: begin
          movementEnable <= '0;
          if (pressPulse && !estopSync_p1 && (&inRange)) begin
            state          <= SUP_RUN;
            movementEnable <= runMask;
          end
        end
        SUP_RUN: begin
          if (estopSync_p1 || !(&inRange)) begin
            state          <= SUP_FAULT;
            faultAxis      <= ~inRange;
            movementEnable <= '0;
          end else if (pressPulse) begin
            state          <= SUP_IDLE;
            movementEnable <= '0;
          end else begin
            movementEnable <= runMask;
          end
        end
        SUP_FAULT: begin
          movementEnable <= '0;
          if (pressPulse && !estopSync_p1 && (&inRange)) begin
            state     <= SUP_IDLE;
            faultAxis <= 3'b000;
          end
        end
        default: begin
          state          <= SUP_IDLE;
          faultAxis      <= 3'b000;
          movementEnable <= '0;
        end
      endcase
    end
  end

  assign supState = state;

endmodule

// File: tb/tb_axis_limit_supervisor.sv
// Scoreboard bench for axis_limit_supervisor with a short debounce window.
module tb_axis_limit_supervisor;

  logic        clk;
  logic        reset;
  logic        startButton;
  logic        estop;
  logic [15:0] xAxisPointer;
  logic [15:0] yAxisPointer;
  logic [15:0] zAxisPointer;
  logic [6:0]  movementEnable;
  logic [1:0]  supState;
  logic [2:0]  faultAxis;

  axis_limit_supervisor #(
    .DEBOUNCE (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .startButton    (startButton),
    .estop          (estop),
    .xAxisPointer   (xAxisPointer),
    .yAxisPointer   (yAxisPointer),
    .zAxisPointer   (zAxisPointer),
    .movementEnable (movementEnable),
    .supState       (supState),
    .faultAxis      (faultAxis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [11:0] want;
  } entry_t;

  entry_t sb[$];
  entry_t monEntry;
  int     testsRun    = 0;
  int     testsFailed = 0;

  function automatic logic [11:0] mk(input logic [1:0] s, input logic [2:0] f, input logic [6:0] me);
    return {s, f, me};
  endfunction

  function automatic logic [11:0] obs();
    return {supState, faultAxis, movementEnable};
  endfunction

  task automatic checkVal(input string tag, input logic [11:0] got, input logic [11:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("FAIL %s: got state=%b fault=%b en=%b, expected state=%b fault=%b en=%b",
               tag, got[11:10], got[9:7], got[6:0], want[11:10], want[9:7], want[6:0]);
    end
  endtask

  // Outputs are compared one time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      monEntry = sb.pop_front();
      checkVal(monEntry.tag, obs(), monEntry.want);
    end
  end

  // One clock: push the expectation for the coming edge, then move to the next falling edge.
  task automatic cyc(input string tag, input logic [11:0] want);
    entry_t e;
    e.tag  = tag;
    e.want = want;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Hold start for n cycles then release for 3. With a 2-flop sync and 4-cycle hold, a
  // qualifying press changes state at the 7th edge after the hold begins.
  task automatic press(input string tag, input int n, input logic [11:0] pre,
                       input logic [11:0] post, input int estopAt);
    for (int i = 1; i <= n + 3; i++) begin
      startButton = (i <= n) ? 1'b0 : 1'b1;
      if (estopAt != 0 && i == estopAt) estop = 1'b1;
      cyc(tag, (n >= 4 && i >= 7) ? post : pre);
    end
  endtask

  localparam logic [11:0] IDLE0   = 12'b00_000_0000000;
  localparam logic [11:0] RUN_ALL = 12'b01_000_1111111;
  localparam logic [11:0] F0      = 12'b10_000_0000000;

  initial begin
    reset        = 1'b1;
    startButton  = 1'b1;
    estop        = 1'b0;
    xAxisPointer = 16'd1000;
    yAxisPointer = 16'd1000;
    zAxisPointer = 16'd1000;
    repeat (3) @(negedge clk);
    checkVal("resetState", obs(), IDLE0);
    reset = 1'b0;
    cyc("idle", IDLE0);
    cyc("idle", IDLE0);

    press("armRun", 4, IDLE0, RUN_ALL, 0);

    xAxisPointer = 16'd2600; cyc("xAtUpper", mk(2'b01, 3'b000, 7'b1101111));
    xAxisPointer = 16'd2664; cyc("xOvertravelEdge", mk(2'b01, 3'b000, 7'b1101111));
    xAxisPointer = 16'd0;    cyc("xAtLower", mk(2'b01, 3'b000, 7'b1011111));
    xAxisPointer = 16'd1000; cyc("xMid", RUN_ALL);

    yAxisPointer = 16'd2365; cyc("yTrip", mk(2'b10, 3'b010, 7'd0));
    press("pressOutOfRange", 4, mk(2'b10, 3'b010, 7'd0), mk(2'b10, 3'b010, 7'd0), 0);
    yAxisPointer = 16'd2300; cyc("faultSticky", mk(2'b10, 3'b010, 7'd0));
    press("faultClear", 4, mk(2'b10, 3'b010, 7'd0), IDLE0, 0);
    press("rearmAtLimit", 4, IDLE0, mk(2'b01, 3'b000, 7'b1110111), 0);
    yAxisPointer = 16'd1000; cyc("yMid", RUN_ALL);

    zAxisPointer = 16'hFFFF; cyc("zUnderflow", mk(2'b10, 3'b100, 7'd0));
    zAxisPointer = 16'd1000;
    press("zClear", 4, mk(2'b10, 3'b100, 7'd0), IDLE0, 0);
    press("zRearm", 4, IDLE0, RUN_ALL, 0);

    press("estopWithPress", 4, RUN_ALL, F0, 5);
    press("estopHeldPress", 4, F0, F0, 0);
    estop = 1'b0;
    repeat (3) cyc("estopReleased", F0);
    press("estopClear", 4, F0, IDLE0, 0);
    press("estopRearm", 4, IDLE0, RUN_ALL, 0);

    estop = 1'b1;
    cyc("estopSync1", RUN_ALL);
    cyc("estopSync2", RUN_ALL);
    cyc("estopTrip", F0);
    estop = 1'b0;
    repeat (2) cyc("estopTripHold", F0);
    press("estopTripClear", 4, F0, IDLE0, 0);

    estop = 1'b1;
    repeat (2) cyc("idleEstop", IDLE0);
    press("idlePressEstop", 4, IDLE0, IDLE0, 0);
    estop = 1'b0;
    repeat (2) cyc("idleEstopOff", IDLE0);

    press("armForBoth", 4, IDLE0, RUN_ALL, 0);
    estop = 1'b1;
    cyc("bothSync1", RUN_ALL);
    cyc("bothSync2", RUN_ALL);
    xAxisPointer = 16'd2700;
    cyc("estopAndAxis", mk(2'b10, 3'b001, 7'd0));
    estop = 1'b0;
    xAxisPointer = 16'd1000;
    repeat (2) cyc("bothHold", mk(2'b10, 3'b001, 7'd0));
    press("bothClear", 4, mk(2'b10, 3'b001, 7'd0), IDLE0, 0);

    press("shortPress", 3, IDLE0, IDLE0, 0);
    press("longPress", 20, IDLE0, RUN_ALL, 0);
    cyc("longPressHold", RUN_ALL);

    reset = 1'b1;
    #1;
    checkVal("resetMidRun", obs(), IDLE0);
    @(negedge clk);
    reset = 1'b0;
    cyc("afterReset", IDLE0);
    cyc("afterReset", IDLE0);

    checkVal("scoreboardDrain", 12'(sb.size()), 12'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
